// File: rtl/mapper_mem_pkg.sv
// Shared types and constants for the mapper memory sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mapper_mem_pkg;

   // Default width of the mapper's translated PRG/CHR addresses
   localparam int DEF_ADDR_W = 22;

   // Value returned by a read that never reaches a memory
   localparam logic [7:0] OPEN_BUS = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      MEM,
      VRAM_A,
      VRAM_D,
      DONE
   } state_t;

   typedef enum logic {
      CH_PRG = 1'b0,
      CH_CHR = 1'b1
   } chan_t;

   // The channel that did not win last time
   function automatic chan_t other_chan(input chan_t c);
      return (c == CH_PRG) ? CH_CHR : CH_PRG;
   endfunction

endpackage

// File: rtl/mem_req_slot.sv
// Per-channel pending-request latch: captures one strobe and holds it until the sequencer retires it.
// Latency: busy and held fields valid the cycle after the strobe; clear drops busy on the next edge.
// Backpressure: strobes arriving while busy are dropped; a simultaneous read+write is taken as a write.
module mem_req_slot
   import mapper_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_stb,
   input  logic              wr_stb,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              allow,
   input  logic              vram_ce,
   input  logic              vram_a10,
   input  logic              clear,
   output logic              busy,
   output logic [ADDR_W-1:0] slot_addr,
   output logic [DATA_W-1:0] slot_wdata,
   output logic              slot_we,
   output logic              slot_allow,
   output logic              slot_vram_ce,
   output logic              slot_vram_a10
);

   // Hold one request from strobe to completion; new strobes are ignored while occupied
   always_ff @(posedge clk) begin
      if (reset) begin
         busy          <= 1'b0;
         slot_addr     <= '0;
         slot_wdata    <= '0;
         slot_we       <= 1'b0;
         slot_allow    <= 1'b0;
         slot_vram_ce  <= 1'b0;
         slot_vram_a10 <= 1'b0;
      end else if (clear) begin
         busy <= 1'b0;
      end else if (!busy && (rd_stb || wr_stb)) begin
         busy          <= 1'b1;
         slot_addr     <= addr;
         slot_wdata    <= wdata;
         slot_we       <= wr_stb;
         slot_allow    <= allow;
         slot_vram_ce  <= vram_ce;
         slot_vram_a10 <= vram_a10;
      end
   end

endmodule

// File: rtl/mapper_mem_sequencer.sv
// Turns mapper PRG/CHR accesses into internal VRAM cycles or external req/ack memory transactions.
// Latency: strobe N -> done N+3 (zero-wait ack or blocked access), N+4 for VRAM; busy clears one cycle after done.
// Backpressure: one outstanding request per channel, extra strobes dropped; MEM waits for mem_ack (bounded with MEM_TIMEOUT_EN).
module mapper_mem_sequencer
   import mapper_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prg_read,
   input  logic              prg_write,
   input  logic [ADDR_W-1:0] prg_addr,
   input  logic              prg_allow,
   input  logic [DATA_W-1:0] prg_wdata,
   output logic [DATA_W-1:0] prg_rdata,
   output logic              prg_busy,
   output logic              prg_done,
   input  logic              chr_read,
   input  logic              chr_write,
   input  logic [ADDR_W-1:0] chr_addr,
   input  logic              chr_allow,
   input  logic [DATA_W-1:0] chr_wdata,
   input  logic              vram_ce,
   input  logic              vram_a10,
   output logic [DATA_W-1:0] chr_rdata,
   output logic              chr_busy,
   output logic              chr_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [10:0]       vram_addr,
   output logic              vram_we,
   input  logic [DATA_W-1:0] vram_rdata
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              timeout_err
`endif
);

   localparam logic [DATA_W-1:0] OPEN_RD = DATA_W'(OPEN_BUS);

   state_t            state, state_nxt;
   chan_t             last_grant, grant_nxt;
   logic              g_allow, g_vce;
   logic              prg_clear, chr_clear;
   logic              rd_load;
   logic [DATA_W-1:0] rd_val;
   logic              wd_expired;

   logic [ADDR_W-1:0] p_addr, c_addr, cur_addr;
   logic [DATA_W-1:0] p_wdata, c_wdata, cur_wdata;
   logic              p_we, c_we, cur_we;
   logic              p_allow, c_allow, cur_allow;
   logic              p_vce, c_vce, cur_vce;
   logic              p_a10, c_a10, cur_a10;
   logic              cur_chr;

   mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_prg_slot (
      .clk           (clk),
      .reset         (reset),
      .rd_stb        (prg_read),
      .wr_stb        (prg_write),
      .addr          (prg_addr),
      .wdata         (prg_wdata),
      .allow         (prg_allow),
      .vram_ce       (1'b0),
      .vram_a10      (1'b0),
      .clear         (prg_clear),
      .busy          (prg_busy),
      .slot_addr     (p_addr),
      .slot_wdata    (p_wdata),
      .slot_we       (p_we),
      .slot_allow    (p_allow),
      .slot_vram_ce  (p_vce),
      .slot_vram_a10 (p_a10)
   );

   mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chr_slot (
      .clk           (clk),
      .reset         (reset),
      .rd_stb        (chr_read),
      .wr_stb        (chr_write),
      .addr          (chr_addr),
      .wdata         (chr_wdata),
      .allow         (chr_allow),
      .vram_ce       (vram_ce),
      .vram_a10      (vram_a10),
      .clear         (chr_clear),
      .busy          (chr_busy),
      .slot_addr     (c_addr),
      .slot_wdata    (c_wdata),
      .slot_we       (c_we),
      .slot_allow    (c_allow),
      .slot_vram_ce  (c_vce),
      .slot_vram_a10 (c_a10)
   );

   // last_grant doubles as the channel currently in service
   assign cur_chr   = (last_grant == CH_CHR);
   assign cur_addr  = cur_chr ? c_addr  : p_addr;
   assign cur_wdata = cur_chr ? c_wdata : p_wdata;
   assign cur_we    = cur_chr ? c_we    : p_we;
   assign cur_allow = cur_chr ? c_allow : p_allow;
   assign cur_vce   = cur_chr ? c_vce   : p_vce;
   assign cur_a10   = cur_chr ? c_a10   : p_a10;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] wd_cnt;

   assign wd_expired = (state == MEM) && !mem_ack && (wd_cnt == 8'(TIMEOUT_CYC - 1));

   // Count cycles spent waiting in MEM; a missing ack raises a sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         wd_cnt <= (state == MEM) ? wd_cnt + 8'd1 : 8'd0;
         if (wd_expired) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   // No watchdog in this build: MEM waits for mem_ack indefinitely
   logic [7:0] timeout_cfg_unused;
   assign timeout_cfg_unused = 8'(TIMEOUT_CYC);
   assign wd_expired = 1'b0;
`endif

   // State register and grant history
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= CH_PRG;
      end else begin
         state <= state_nxt;
         if (state == IDLE && (prg_busy || chr_busy)) begin
            last_grant <= grant_nxt;
         end
      end
   end

   // Next state: arbitrate in IDLE, then route by allow / vram_ce
   always_comb begin
      state_nxt = state;
      grant_nxt = last_grant;
      g_allow   = 1'b0;
      g_vce     = 1'b0;
      case (state)
         IDLE: begin
            if (prg_busy || chr_busy) begin
               if (prg_busy && chr_busy) begin
                  grant_nxt = other_chan(last_grant);
               end else begin
                  grant_nxt = chr_busy ? CH_CHR : CH_PRG;
               end
               g_allow = (grant_nxt == CH_CHR) ? c_allow : p_allow;
               g_vce   = (grant_nxt == CH_CHR) && c_vce;
               // A blocked access skips memory but idles one cycle in VRAM_D so
               // it completes on the same schedule as a zero-wait memory access
               if (!g_allow) begin
                  state_nxt = VRAM_D;
               end else if (g_vce) begin
                  state_nxt = VRAM_A;
               end else begin
                  state_nxt = MEM;
               end
            end
         end
         MEM: begin
            if (mem_ack || wd_expired) begin
               state_nxt = DONE;
            end
         end
         VRAM_A:  state_nxt = VRAM_D;
         VRAM_D:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state and the in-service slot
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      vram_addr = '0;
      vram_we   = 1'b0;
      prg_done  = 1'b0;
      chr_done  = 1'b0;
      rd_load   = 1'b0;
      rd_val    = OPEN_RD;
      case (state)
         MEM: begin
            mem_req   = 1'b1;
            mem_we    = cur_we;
            mem_addr  = cur_addr;
            mem_wdata = cur_wdata;
            rd_load   = !cur_we && (mem_ack || wd_expired);
            rd_val    = mem_ack ? mem_rdata : OPEN_RD;
         end
         VRAM_A: begin
            // Internal VRAM shares the external write-data bus
            vram_addr = {cur_a10, cur_addr[9:0]};
            vram_we   = cur_we;
            mem_wdata = cur_we ? cur_wdata : '0;
         end
         VRAM_D: begin
            rd_load = !cur_we;
            rd_val  = (cur_allow && cur_vce) ? vram_rdata : OPEN_RD;
         end
         DONE: begin
            prg_done = !cur_chr;
            chr_done = cur_chr;
         end
         default: begin
         end
      endcase
      prg_clear = prg_done;
      chr_clear = chr_done;
   end

   // Per-channel read data, held until the next completed read on that channel
   always_ff @(posedge clk) begin
      if (reset) begin
         prg_rdata <= OPEN_RD;
         chr_rdata <= OPEN_RD;
      end else if (rd_load) begin
         if (cur_chr) begin
            chr_rdata <= rd_val;
         end else begin
            prg_rdata <= rd_val;
         end
      end
   end

endmodule

// File: tb/tb_mapper_mem_sequencer.sv
// Bench for mapper_mem_sequencer: vector table plus hand sequences, completions checked against a scoreboard.
// Latency: measured per transaction from strobe cycle to done pulse.
// Backpressure: memory model acks after a programmable delay; can be held off or made to ack spuriously.
module tb_mapper_mem_sequencer;

   localparam int AW   = 22;
   localparam int DW   = 8;
   localparam int TCYC = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          prg_read, prg_write, prg_allow, prg_busy, prg_done;
   logic [AW-1:0] prg_addr;
   logic [DW-1:0] prg_wdata, prg_rdata;
   logic          chr_read, chr_write, chr_allow, chr_busy, chr_done, vram_ce, vram_a10;
   logic [AW-1:0] chr_addr;
   logic [DW-1:0] chr_wdata, chr_rdata;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [10:0]   vram_addr;
   logic          vram_we;
   logic [DW-1:0] vram_rdata;
`ifdef MEM_TIMEOUT_EN
   logic          timeout_err;
`endif

   mapper_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TCYC)) dut (
      .clk        (clk),
      .reset      (reset),
      .prg_read   (prg_read),
      .prg_write  (prg_write),
      .prg_addr   (prg_addr),
      .prg_allow  (prg_allow),
      .prg_wdata  (prg_wdata),
      .prg_rdata  (prg_rdata),
      .prg_busy   (prg_busy),
      .prg_done   (prg_done),
      .chr_read   (chr_read),
      .chr_write  (chr_write),
      .chr_addr   (chr_addr),
      .chr_allow  (chr_allow),
      .chr_wdata  (chr_wdata),
      .vram_ce    (vram_ce),
      .vram_a10   (vram_a10),
      .chr_rdata  (chr_rdata),
      .chr_busy   (chr_busy),
      .chr_done   (chr_done),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .vram_addr  (vram_addr),
      .vram_we    (vram_we),
      .vram_rdata (vram_rdata)
`ifdef MEM_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard of expected completions, in order
   typedef struct {
      logic       ch;
      logic [7:0] rd;
   } exp_t;
   exp_t sb[$];

   // Monitor state, sampled on the falling edge
   int            mreq_cyc, vwe_cnt, done_cnt, last_done_cyc, busy_on_cyc, busy_off_cyc, strobe_cyc;
   logic [AW-1:0] seen_maddr;
   logic          seen_mwe;
   logic [7:0]    seen_mwd, seen_vwd;
   logic [10:0]   seen_vaddr;
   logic          prev_busy = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            mreq_cyc++;
            seen_maddr = mem_addr;
            seen_mwe   = mem_we;
            seen_mwd   = mem_wdata;
         end
         if (vram_we) begin
            vwe_cnt++;
            seen_vaddr = vram_addr;
            seen_vwd   = mem_wdata;
         end
         if ((prg_busy | chr_busy) && !prev_busy) busy_on_cyc = cyc;
         if (!(prg_busy | chr_busy) && prev_busy) busy_off_cyc = cyc;
         prev_busy = prg_busy | chr_busy;
         if (prg_done || chr_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_done", {30'd0, prg_done, chr_done}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("done_channel", {31'd0, chr_done}, {31'd0, e.ch});
               chk("done_rdata", e.ch ? chr_rdata : prg_rdata, e.rd);
            end
         end
      end
   end

   // External memory model: ack after ack_dly extra cycles, optional stray ack
   logic       resp_en = 1'b1;
   logic       stray_ack = 1'b0;
   int         ack_dly = 0;
   logic [7:0] resp_data = 8'h00;
   initial begin
      int wcnt;
      wcnt      = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (mem_req && resp_en) begin
            if (wcnt >= ack_dly) begin
               mem_ack   = 1'b1;
               mem_rdata = resp_data;
               wcnt      = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
         if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hC7;
            stray_ack = 1'b0;
         end
      end
   end

   // Synchronous VRAM model, write data taken from mem_wdata
   logic [7:0] vram [2048];
   initial begin
      logic [10:0] va;
      logic        vw;
      logic [7:0]  vd;
      vram_rdata = '0;
      for (int i = 0; i < 2048; i++) vram[i] = 8'(i) ^ 8'h3C;
      forever begin
         @(negedge clk);
         va = vram_addr;
         vw = vram_we;
         vd = mem_wdata;
         @(posedge clk);
         #1;
         if (vw) vram[va] = vd;
         vram_rdata = vram[va];
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      mreq_cyc = 0; vwe_cnt = 0; done_cnt = 0;
      last_done_cyc = 0; busy_on_cyc = 0; busy_off_cyc = 0;
   endtask

   task automatic pulse(input logic pr, input logic pw, input logic cr, input logic cw);
      prg_read = pr; prg_write = pw; chr_read = cr; chr_write = cw;
      strobe_cyc = cyc;
      tick();
      prg_read = 1'b0; prg_write = 1'b0; chr_read = 1'b0; chr_write = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 200 && (sb.size() != 0 || prg_busy || chr_busy); k++) tick();
      tick();
      tick();
      chk({nm, "_drain"}, sb.size(), 0);
   endtask

   typedef struct {
      logic       chr, we, allow, vce, a10;
      logic [21:0] addr;
      logic [7:0] wd, md;
      int         dly;
      logic [7:0] rd;
      int         lat, mreq, vwe;
   } vec_t;
   localparam int NV = 10;
   vec_t tv[NV];

   initial begin
      //           chr we al vce a10 addr          wd     md     dly rd     lat mreq vwe
      tv[0] = '{1'b0,1'b0,1'b1,1'b0,1'b0,22'h004010,8'h00,8'h5A,3,8'h5A,6,4,0};
      tv[1] = '{1'b0,1'b0,1'b1,1'b0,1'b0,22'h3FFFFF,8'h00,8'hA5,0,8'hA5,3,1,0};
      tv[2] = '{1'b0,1'b1,1'b1,1'b0,1'b0,22'h008000,8'hC3,8'h99,0,8'hA5,3,1,0};
      tv[3] = '{1'b1,1'b0,1'b1,1'b0,1'b0,22'h012345,8'h00,8'h77,1,8'h77,4,2,0};
      tv[4] = '{1'b1,1'b1,1'b1,1'b1,1'b1,22'h0002A5,8'h33,8'h00,0,8'h77,4,0,1};
      tv[5] = '{1'b1,1'b0,1'b1,1'b1,1'b1,22'h3FF2A5,8'h00,8'h00,0,8'h33,4,0,0};
      tv[6] = '{1'b1,1'b0,1'b1,1'b1,1'b0,22'h000155,8'h00,8'h00,0,8'h69,4,0,0};
      tv[7] = '{1'b0,1'b1,1'b0,1'b0,1'b0,22'h004000,8'hEE,8'h00,0,8'hA5,3,0,0};
      tv[8] = '{1'b0,1'b0,1'b0,1'b0,1'b0,22'h004001,8'h00,8'h12,0,8'hFF,3,0,0};
      tv[9] = '{1'b1,1'b0,1'b0,1'b1,1'b1,22'h000010,8'h00,8'h12,0,8'hFF,3,0,0};

      reset = 1'b1;
      prg_read = 0; prg_write = 0; prg_addr = '0; prg_allow = 0; prg_wdata = '0;
      chr_read = 0; chr_write = 0; chr_addr = '0; chr_allow = 0; chr_wdata = '0;
      vram_ce = 0; vram_a10 = 0;
      clr_mon();
      repeat (3) tick();

      // Reset state
      chk("rst_prg_rdata", prg_rdata, 8'hFF);
      chk("rst_chr_rdata", chr_rdata, 8'hFF);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", {prg_busy, chr_busy}, 0);
      chk("rst_done", {prg_done, chr_done}, 0);
      chk("rst_vram", {vram_addr, vram_we}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      reset = 1'b0;
      tick();

      // Simultaneous strobes after reset: CHR first, then PRG
      clr_mon();
      ack_dly = 0; resp_data = 8'h11;
      prg_addr = 22'h000100; prg_allow = 1;
      chr_addr = 22'h000200; chr_allow = 1; vram_ce = 0;
      sb.push_back(exp_t'{1'b1, 8'h11});
      sb.push_back(exp_t'{1'b0, 8'h11});
      pulse(1, 0, 1, 0);
      drain("arb");
      chk("arb_done_cnt", done_cnt, 2);
      chk("arb_latency", last_done_cyc - strobe_cyc, 6);
      chk("arb_mreq_cyc", mreq_cyc, 2);

      // Single-transaction vectors
      for (int i = 0; i < NV; i++) begin
         clr_mon();
         ack_dly = tv[i].dly; resp_data = tv[i].md;
         if (tv[i].chr) begin
            chr_addr = tv[i].addr; chr_allow = tv[i].allow; chr_wdata = tv[i].wd;
            vram_ce = tv[i].vce; vram_a10 = tv[i].a10;
         end else begin
            prg_addr = tv[i].addr; prg_allow = tv[i].allow; prg_wdata = tv[i].wd;
         end
         sb.push_back(exp_t'{tv[i].chr, tv[i].rd});
         pulse(!tv[i].chr && !tv[i].we, !tv[i].chr && tv[i].we,
               tv[i].chr && !tv[i].we, tv[i].chr && tv[i].we);
         drain($sformatf("v%0d", i));
         chk($sformatf("v%0d_latency", i), last_done_cyc - strobe_cyc, tv[i].lat);
         chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
         chk($sformatf("v%0d_busy_on", i), busy_on_cyc - strobe_cyc, 1);
         chk($sformatf("v%0d_busy_off", i), busy_off_cyc - strobe_cyc, tv[i].lat + 1);
         chk($sformatf("v%0d_mreq_cyc", i), mreq_cyc, tv[i].mreq);
         chk($sformatf("v%0d_vram_we_cnt", i), vwe_cnt, tv[i].vwe);
         if (tv[i].mreq > 0) begin
            chk($sformatf("v%0d_mem_addr", i), seen_maddr, tv[i].addr);
            chk($sformatf("v%0d_mem_we", i), seen_mwe, tv[i].we);
         end
         if (tv[i].vwe > 0) begin
            chk($sformatf("v%0d_vram_addr", i), seen_vaddr, {tv[i].a10, tv[i].addr[9:0]});
            chk($sformatf("v%0d_vram_wdata", i), seen_vwd, tv[i].wd);
         end
      end

      // Strobe while busy is dropped
      clr_mon();
      ack_dly = 2; resp_data = 8'h42;
      prg_addr = 22'h001000; prg_allow = 1; prg_wdata = 8'h5F;
      sb.push_back(exp_t'{1'b0, 8'h42});
      pulse(1, 0, 0, 0);
      prg_write = 1'b1;
      tick();
      prg_write = 1'b0;
      drain("busy_drop");
      chk("busy_drop_done_cnt", done_cnt, 1);
      chk("busy_drop_mreq_cyc", mreq_cyc, 3);
      chk("busy_drop_mem_we", seen_mwe, 0);

      // Read and write together: write wins, rdata unchanged
      clr_mon();
      ack_dly = 0; resp_data = 8'hE1;
      prg_addr = 22'h002000; prg_wdata = 8'h9C;
      sb.push_back(exp_t'{1'b0, 8'h42});
      pulse(1, 1, 0, 0);
      drain("rw");
      chk("rw_mem_we", seen_mwe, 1);
      chk("rw_mem_wdata", seen_mwd, 8'h9C);

      // Reset while mem_req is high, then a stray ack
      clr_mon();
      resp_en = 1'b0;
      prg_addr = 22'h001234; prg_allow = 1;
      sb.push_back(exp_t'{1'b0, 8'h00});
      pulse(1, 0, 0, 0);
      for (int k = 0; k < 10 && !mem_req; k++) tick();
      chk("rst_mid_mreq_before", mem_req, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_mreq_after", mem_req, 0);
      chk("rst_mid_busy", {prg_busy, chr_busy}, 0);
      chk("rst_mid_prg_rdata", prg_rdata, 8'hFF);
      sb.delete();
      stray_ack = 1'b1;
      repeat (3) tick();
      chk("stray_ack_done_cnt", done_cnt, 0);
      chk("stray_ack_mreq", mem_req, 0);
      chk("stray_ack_busy", prg_busy, 0);
      chk("stray_ack_rdata", prg_rdata, 8'hFF);
      resp_en = 1'b1;

`ifdef MEM_TIMEOUT_EN
      // Load known data, then let a read time out
      clr_mon();
      ack_dly = 0; resp_data = 8'h5A;
      sb.push_back(exp_t'{1'b0, 8'h5A});
      pulse(1, 0, 0, 0);
      drain("to_pre");
      chk("to_err_clear", timeout_err, 0);
      clr_mon();
      resp_en = 1'b0;
      sb.push_back(exp_t'{1'b0, 8'hFF});
      pulse(1, 0, 0, 0);
      drain("to");
      chk("to_mreq_cyc", mreq_cyc, TCYC);
      chk("to_latency", last_done_cyc - strobe_cyc, TCYC + 2);
      chk("to_err_set", timeout_err, 1);
      repeat (5) tick();
      chk("to_err_sticky", timeout_err, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("to_err_reset", timeout_err, 0);
      resp_en = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mapper_mem_sequencer.md
Name: mapper_mem_sequencer

Overview:
- Sits directly downstream of the cartridge mapper (MMC1 and siblings).
- Takes the mapper's translated PRG and CHR addresses and turns them into transactions. CHR accesses with vram_ce go to the internal 2 KB VRAM; everything else goes to one shared external memory port with a req/ack handshake.
- Arbitrates CPU (PRG) and PPU (CHR) requests, honours the mapper allow signals, and holds read data per channel.

Parameters:
- ADDR_W, 22, width of mapper output addresses and mem_addr.
- DATA_W, 8, data width of all data buses.
- TIMEOUT_CYC, 255, mem_ack watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- prg_read / prg_write  in  1  single-cycle PRG strobes.
- prg_addr  in  ADDR_W  mapper prg_aout.
- prg_allow  in  1  mapper prg_allow.
- prg_wdata  in  DATA_W  CPU write data.
- prg_rdata  out  DATA_W  last PRG read result, held.
- prg_busy  out  1  PRG request pending or in service.
- prg_done  out  1  one-cycle completion pulse.
- chr_read / chr_write  in  1  single-cycle CHR strobes.
- chr_addr  in  ADDR_W  mapper chr_aout.
- chr_allow  in  1  mapper chr_allow.
- chr_wdata  in  DATA_W  PPU write data.
- vram_ce  in  1  route this CHR access to internal VRAM.
- vram_a10  in  1  mapper mirroring line.
- chr_rdata, chr_busy, chr_done  out  DATA_W/1/1  CHR counterparts of the PRG outputs.
- mem_req  out  1  external request, held until ack.
- mem_we  out  1  write qualifier.
- mem_addr  out  ADDR_W  external address.
- mem_wdata  out  DATA_W  external write data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  DATA_W  valid in the mem_ack cycle.
- vram_addr  out  11  {vram_a10, chr_addr[9:0]}.
- vram_we  out  1  internal VRAM write strobe.
- vram_rdata  in  DATA_W  synchronous VRAM read data, valid one cycle after the address.

Behaviour:
- Reset values:
  - All outputs 0, except prg_rdata = chr_rdata = 8'hFF.
  - State IDLE, no requests pending, last_grant = PRG.
- Request capture:
  - A strobe latches a per-channel slot holding addr, wdata, we, allow and (CHR only) vram_ce/vram_a10.
  - busy rises the next cycle.
  - A strobe arriving while that channel is busy is ignored.
  - If read and write strobes are simultaneous, write wins.
- States:
  - IDLE: arbitrates between pending slots.
  - MEM: mem_req high; waits for mem_ack.
  - VRAM_A: vram_addr driven; vram_we high for writes.
  - VRAM_D: captures vram_rdata on reads.
  - DONE: asserts done for one cycle, clears the slot, returns to IDLE.
- Arbitration in IDLE:
  - If only one slot is pending, grant it.
  - If both are pending, grant the channel not equal to last_grant; on reset this means CHR goes first.
  - Update last_grant on every grant.
- Routing for the granted request:
  - allow = 0: go straight to DONE with no memory access. Reads return 8'hFF (open bus).
  - CHR with vram_ce = 1: VRAM_A, then VRAM_D, then DONE.
  - Otherwise: MEM.
- MEM handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high.
  - On the mem_ack edge: capture rdata (reads only), drop mem_req, go to DONE.
  - mem_ack while mem_req is low is ignored.
- Latency, strobe in cycle N:
  - mem_req high from N+2.
  - Zero-wait ack in N+2 gives done in N+3 and busy low in N+4.
  - VRAM path gives done in N+4.
  - allow = 0 gives done in N+3.
- Write accesses leave rdata unchanged.
- Reset mid-transaction: the next cycle has mem_req = 0 and all slots cleared. The external memory must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - An 8-bit watchdog counts cycles in MEM.
  - If it reaches TIMEOUT_CYC without mem_ack: drop mem_req, return 8'hFF as read data, go to DONE, and set a sticky output timeout_err (1 bit).
  - timeout_err clears only on reset.
- Disabled: no counter and no timeout_err port; MEM waits indefinitely.

Decomposition:
- Package mapper_mem_pkg holds:
  - the state enum (IDLE, MEM, VRAM_A, VRAM_D, DONE);
  - the channel id type (PRG/CHR);
  - the OPEN_BUS = 8'hFF constant;
  - the default ADDR_W.
- Sub-module mem_req_slot: per-channel pending latch with busy/clear, instantiated twice.

Test Plan:
- PRG read, addr 22'h00_4010, allow = 1, memory acks 3 cycles after mem_req -> mem_addr 22'h004010, mem_we = 0, prg_rdata = mem_rdata 8'h5A, prg_done exactly once.
- CHR write, vram_ce = 1, vram_a10 = 1, chr_addr[9:0] = 10'h2A5, data 8'h33 -> vram_addr 11'h6A5, one vram_we pulse, mem_req never asserted.
- PRG and CHR strobes in the same cycle after reset -> CHR serviced first, then PRG; both done pulses seen, ordered CHR then PRG.
- PRG write with allow = 0 -> no mem_req, prg_done in N+3, prg_rdata unchanged; PRG read with allow = 0 -> prg_rdata = 8'hFF.
- Reset asserted while mem_req is high -> mem_req 0 next cycle, busy 0, later mem_ack ignored.
- With MEM_TIMEOUT_EN, TIMEOUT_CYC = 8, no ack -> mem_req drops after 8 cycles, prg_rdata = 8'hFF, timeout_err stays 1 until reset.
